// File: rtl/shift_add_ctrl.sv
// Sequencer for a 4x4 unsigned shift-add multiplier driving an external
// 74181-style ALU; owns the accumulator/multiplier shift register.
module shift_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout,
  output logic [2*WIDTH-1:0] product,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             c_q, c_d;
  logic [1:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    q_d     = q_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = multiplicand;
          q_d     = multiplier;
          acc_d   = '0;
          c_d     = 1'b0;
          cnt_d   = 2'd0;
          state_d = ADD;
        end
      end
      ADD: begin
        acc_d   = alu_f;
        c_d     = alu_cout;
        state_d = SHIFT;
      end
      SHIFT: begin
        // 9-bit logical right shift of {c, acc, q}
        acc_d   = {c_q, acc_q[WIDTH-1:1]};
        q_d     = {acc_q[0], q_q[WIDTH-1:1]};
        c_d     = 1'b0;
        cnt_d   = cnt_q + 2'd1;
        state_d = (cnt_q == 2'd3) ? DONE : ADD;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_m   = 1'b1;
    alu_s   = 4'b1111;
    alu_cin = 1'b1;
    alu_a   = acc_q;
    alu_b   = '0;
    if (state_q == ADD) begin
      alu_m = 1'b0;
      alu_s = 4'b1001;
      alu_b = q_q[0] ? mcand_q : '0;
    end
  end

  assign product = {acc_q, q_q};
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule
